// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: CPU-side RX/TX FIFOs in front of the uart register port.
// A Moore polling FSM owns the uart port, draining RX bytes and feeding TX bytes.
module uart_fifo_bridge #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a0,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic       rnw,
    input  logic       cs,
    output logic       u_a0,
    output logic [7:0] u_din,
    input  logic [7:0] u_dout,
    output logic       u_rnw,
    output logic       u_cs
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0] cnt_t;
    localparam cnt_t FULL = cnt_t'(DEPTH);
    localparam ptr_t PTR_ONE = ptr_t'(1);
    typedef enum logic [2:0] {POLL, RX_PEEK, RX_ACK, TX_WR, TX_WAIT} state_t;
    state_t state_q, state_d;
    logic [7:0] rx_mem [DEPTH];
    logic [7:0] tx_mem [DEPTH];
    ptr_t rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d, tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    cnt_t rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic rx_ovr_q, rx_ovr_d;
    logic rx_push, rx_pop, tx_push, tx_pop;

    always_comb begin
        rx_push  = state_q == RX_PEEK && rx_cnt_q != FULL;
        rx_pop   = cs && rnw && a0 && rx_cnt_q != '0;
        tx_push  = cs && !rnw && a0 && tx_cnt_q != FULL;
        tx_pop   = state_q == TX_WR;
        rx_wr_d  = rx_push ? rx_wr_q + PTR_ONE : rx_wr_q;
        rx_rd_d  = rx_pop ? rx_rd_q + PTR_ONE : rx_rd_q;
        tx_wr_d  = tx_push ? tx_wr_q + PTR_ONE : tx_wr_q;
        tx_rd_d  = tx_pop ? tx_rd_q + PTR_ONE : tx_rd_q;
        rx_cnt_d = rx_cnt_q + cnt_t'(rx_push) - cnt_t'(rx_pop);
        tx_cnt_d = tx_cnt_q + cnt_t'(tx_push) - cnt_t'(tx_pop);
        // A drop while full outranks a same-cycle status-read clear
        rx_ovr_d = (state_q == RX_PEEK && rx_cnt_q == FULL) ? 1'b1 :
                   (cs && rnw && !a0) ? 1'b0 : rx_ovr_q;
        state_d  = POLL;
        unique case (state_q)
            POLL:    state_d = u_dout[0] ? RX_PEEK :
                               (tx_cnt_q != '0 && !u_dout[1]) ? TX_WR : POLL;
            RX_PEEK: state_d = RX_ACK;
            TX_WR:   state_d = TX_WAIT;
            default: state_d = POLL;
        endcase
        u_cs  = state_q == RX_ACK || state_q == TX_WR;
        u_a0  = state_q == RX_PEEK || state_q == RX_ACK || state_q == TX_WR;
        u_rnw = state_q != TX_WR;
        u_din = tx_pop ? tx_mem[tx_rd_q] : 8'h00;
        dout  = a0 ? (rx_cnt_q != '0 ? rx_mem[rx_rd_q] : 8'h00) :
                {4'b0, tx_cnt_q == '0, rx_ovr_q, tx_cnt_q == FULL, rx_cnt_q != '0};
    end

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_q] <= u_dout;
        if (tx_push) tx_mem[tx_wr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= POLL;
            rx_rd_q  <= '0;
            rx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_wr_q  <= '0;
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            rx_ovr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rx_rd_q  <= rx_rd_d;
            rx_wr_q  <= rx_wr_d;
            tx_rd_q  <= tx_rd_d;
            tx_wr_q  <= tx_wr_d;
            rx_cnt_q <= rx_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            rx_ovr_q <= rx_ovr_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: uart behavioural model plus queue-based reference for both FIFOs.
module tb_uart_fifo_bridge;
    logic clk = 0, reset = 1, a0 = 0, rnw = 1, cs = 0;
    logic [7:0] din = 0, dout, u_din, u_dout;
    logic u_a0, u_rnw, u_cs;
    int checks = 0, errors = 0;

    uart_fifo_bridge #(.DEPTH_LOG2(4)) dut (
        .clk(clk), .reset(reset), .a0(a0), .din(din), .dout(dout), .rnw(rnw), .cs(cs),
        .u_a0(u_a0), .u_din(u_din), .u_dout(u_dout), .u_rnw(u_rnw), .u_cs(u_cs)
    );

    always #5 clk = ~clk;

    // uart model: one holding register fed from an injection list, and a busy timer
    logic [7:0] inj_mem [256];
    int inj_wr = 0, inj_rd = 0;
    logic rx_full = 0, busy_stuck = 0, prev_cs = 0;
    logic [7:0] rx_byte = 0;
    int busy_cnt = 0, busy_len = 0, rx_strobes = 0, tx_n = 0, busy_viol = 0, cs_viol = 0;
    logic [7:0] tx_log [1024];
    logic tx_busy;
    assign tx_busy = busy_stuck || busy_cnt != 0;
    assign u_dout = u_a0 ? rx_byte : {6'b0, tx_busy, rx_full};

    always @(posedge clk) begin
        prev_cs <= u_cs;
        if (prev_cs && u_cs) cs_viol <= cs_viol + 1;
        if (u_cs && u_rnw && u_a0) begin
            rx_full <= 0;
            rx_strobes <= rx_strobes + 1;
        end else if (!rx_full && inj_rd != inj_wr) begin
            rx_byte <= inj_mem[inj_rd % 256];
            rx_full <= 1;
            inj_rd <= inj_rd + 1;
        end
        if (u_cs && !u_rnw && u_a0) begin
            tx_log[tx_n % 1024] <= u_din;
            tx_n <= tx_n + 1;
            if (tx_busy) busy_viol <= busy_viol + 1;
            busy_cnt <= busy_len;
        end else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cpu_rd(input logic a, output logic [7:0] d);
        cs = 1; rnw = 1; a0 = a;
        @(negedge clk);
        d = dout;
        @(posedge clk);
        #1 cs = 0;
    endtask

    task automatic cpu_wr(input logic [7:0] v);
        cs = 1; rnw = 0; a0 = 1; din = v;
        @(posedge clk);
        #1 cs = 0; rnw = 1;
    endtask

    task automatic inject(input logic [7:0] b);
        inj_mem[inj_wr % 256] = b;
        inj_wr++;
    endtask

    task automatic drain();
        int k = 0;
        while ((inj_rd != inj_wr || rx_full) && k < 2000) begin
            cyc(1);
            k++;
        end
        check("drain_done", {31'b0, rx_full}, 0);
        cyc(4);
    endtask

    task automatic wait_port(input string tag, input logic want_cs, input logic want_a0);
        int k = 0;
        while (!(u_cs === want_cs && u_a0 === want_a0) && k < 200) begin
            cyc(1);
            k++;
        end
        check(tag, {30'b0, u_cs, u_a0}, {30'b0, want_cs, want_a0});
    endtask

    task automatic wait_tx(input int target);
        int k = 0;
        while (tx_n < target && k < 5000) begin
            cyc(1);
            k++;
        end
        check("tx_count", tx_n, target);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] q [$];
        logic [7:0] tq [$];
        logic ovr;
        int s0, n0, n;
        // reset
        cyc(2);
        reset = 0;
        check("rst_ucs", {31'b0, u_cs}, 0);
        check("rst_urnw", {31'b0, u_rnw}, 1);
        check("rst_ua0", {31'b0, u_a0}, 0);
        check("rst_udin", {24'b0, u_din}, 0);
        cpu_rd(0, d); check("rst_status", {24'b0, d}, 8'h08);
        cpu_rd(1, d); check("rst_empty_rd", {24'b0, d}, 8'h00);
        cpu_rd(0, d); check("rst_status2", {24'b0, d}, 8'h08);
        // RX single, rx_avail already set during the ack strobe
        s0 = rx_strobes;
        inject(8'hA5);
        wait_port("rx1_ack", 1, 1);
        check("rx1_rnw", {31'b0, u_rnw}, 1);
        cpu_rd(0, d); check("rx1_status_ack", {24'b0, d}, 8'h09);
        drain();
        check("rx1_strobes", rx_strobes - s0, 1);
        cpu_rd(0, d); check("rx1_status", {24'b0, d}, 8'h09);
        cpu_rd(1, d); check("rx1_data", {24'b0, d}, 8'hA5);
        cpu_rd(0, d); check("rx1_status_after", {24'b0, d}, 8'h08);
        // RX overrun
        for (int i = 0; i < 17; i++) inject(8'(i));
        drain();
        cpu_rd(0, d); check("ovr_status", {24'b0, d}, 8'h0D);
        cpu_rd(0, d); check("ovr_cleared", {24'b0, d}, 8'h09);
        for (int i = 0; i < 16; i++) begin
            cpu_rd(1, d); check("ovr_data", {24'b0, d}, 32'(i));
        end
        cpu_rd(0, d); check("ovr_empty", {24'b0, d}, 8'h08);
        // simultaneous RX push and CPU pop at count 5
        for (int i = 0; i < 5; i++) inject(8'h50 + 8'(i));
        drain();
        inject(8'h55);
        wait_port("sim_peek", 0, 1);
        cpu_rd(1, d); check("sim_pop", {24'b0, d}, 8'h50);
        drain();
        for (int i = 1; i < 6; i++) begin
            cpu_rd(1, d); check("sim_data", {24'b0, d}, 8'h50 + 32'(i));
        end
        cpu_rd(0, d); check("sim_empty", {24'b0, d}, 8'h08);
        // reset asserted during RX_ACK
        inject(8'h77);
        wait_port("rst_ack", 1, 1);
        reset = 1;
        cyc(1);
        reset = 0;
        check("rstack_ucs", {31'b0, u_cs}, 0);
        check("rstack_ua0", {31'b0, u_a0}, 0);
        cpu_rd(0, d); check("rstack_status", {24'b0, d}, 8'h08);
        drain();
        cpu_rd(0, d); check("rstack_status2", {24'b0, d}, 8'h08);
        // TX burst
        busy_len = 40;
        n0 = tx_n;
        cpu_wr(8'h11); cpu_wr(8'h22); cpu_wr(8'h33);
        wait_tx(n0 + 3);
        cyc(2);
        check("txb_0", {24'b0, tx_log[n0 % 1024]}, 8'h11);
        check("txb_1", {24'b0, tx_log[(n0 + 1) % 1024]}, 8'h22);
        check("txb_2", {24'b0, tx_log[(n0 + 2) % 1024]}, 8'h33);
        cpu_rd(0, d); check("txb_empty", {24'b0, d}, 8'h08);
        // TX full with busy stuck
        busy_stuck = 1;
        cyc(3);
        n0 = tx_n;
        for (int i = 0; i < 16; i++) cpu_wr(8'hC0 + 8'(i));
        cpu_rd(0, d); check("txf_full", {24'b0, d}, 8'h02);
        cpu_wr(8'hFF);
        cpu_rd(0, d); check("txf_full2", {24'b0, d}, 8'h02);
        check("txf_none_sent", tx_n - n0, 0);
        busy_len = 2;
        busy_stuck = 0;
        wait_tx(n0 + 16);
        cyc(30);
        check("txf_exact", tx_n - n0, 16);
        for (int i = 0; i < 16; i++)
            check("txf_data", {24'b0, tx_log[(n0 + i) % 1024]}, 8'hC0 + 32'(i));
        cpu_rd(0, d); check("txf_empty", {24'b0, d}, 8'h08);
        // randomized rounds against queue model
        for (int r = 0; r < 3; r++) begin
            q.delete();
            ovr = 0;
            n = $urandom_range(1, 22);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                inject(d);
                if (q.size() < 16) q.push_back(d); else ovr = 1;
            end
            drain();
            cpu_rd(0, d);
            check("rnd_status", {24'b0, d}, {28'b0, 1'b1, ovr, 1'b0, q.size() != 0});
            while (q.size() != 0) begin
                cpu_rd(1, d); check("rnd_rx", {24'b0, d}, {24'b0, q.pop_front()});
            end
            cpu_rd(0, d); check("rnd_status_end", {24'b0, d}, 8'h08);
            tq.delete();
            busy_len = $urandom_range(0, 12);
            n = $urandom_range(1, 16);
            n0 = tx_n;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                if (tq.size() < 16) tq.push_back(d);
                cpu_wr(d);
                cyc($urandom_range(0, 3));
            end
            wait_tx(n0 + tq.size());
            for (int i = 0; i < tq.size(); i++)
                check("rnd_tx", {24'b0, tx_log[(n0 + i) % 1024]}, {24'b0, tq[i]});
            cyc(20);
            cpu_rd(0, d); check("rnd_tx_empty", {24'b0, d}, 8'h08);
        end
        check("busy_violations", busy_viol, 0);
        check("ucs_back_to_back", cs_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
